// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, branch flush and saturating event counters
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite_ID,
    input  logic              MemtoReg_ID,
    input  logic              MemRead_ID,
    input  logic              MemWrite_ID,
    input  logic              ALUSrc_ID,
    input  logic              RegDst_ID,
    input  logic [1:0]        ALUOp_ID,
    input  logic [DATA_W-1:0] ReadData1_ID,
    input  logic [DATA_W-1:0] ReadData2_ID,
    input  logic [DATA_W-1:0] SignExt_ID,
    input  logic [4:0]        Rs_IF_ID,
    input  logic [4:0]        Rt_IF_ID,
    input  logic [4:0]        Rd_IF_ID,
    input  logic              Flush,
    output logic              RegWrite_ID_EX,
    output logic              MemtoReg_ID_EX,
    output logic              MemRead_ID_EX,
    output logic              MemWrite_ID_EX,
    output logic              ALUSrc_ID_EX,
    output logic              RegDst_ID_EX,
    output logic [1:0]        ALUOp_ID_EX,
    output logic [DATA_W-1:0] ReadData1_ID_EX,
    output logic [DATA_W-1:0] ReadData2_ID_EX,
    output logic [DATA_W-1:0] SignExt_ID_EX,
    output logic [4:0]        Rs_ID_EX,
    output logic [4:0]        Rt_ID_EX,
    output logic [4:0]        Rd_ID_EX,
    output logic              Valid_ID_EX,
    output logic              PC_Write,
    output logic              IF_ID_Write,
    output logic [CNT_W-1:0]  Stall_Count,
    output logic [CNT_W-1:0]  Flush_Count
);
    logic hazard, stall, bubble;

    assign hazard = MemRead_ID_EX & Valid_ID_EX & (Rt_ID_EX != 5'd0) &
                    ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));
    assign stall       = hazard & ~Flush;
    assign bubble      = Flush | stall;
    assign PC_Write    = ~stall;
    assign IF_ID_Write = ~stall;

    // Controls and valid clear on a bubble so the squashed slot can never write anything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite_ID_EX <= 1'b0;
            MemtoReg_ID_EX <= 1'b0;
            MemRead_ID_EX  <= 1'b0;
            MemWrite_ID_EX <= 1'b0;
            ALUSrc_ID_EX   <= 1'b0;
            RegDst_ID_EX   <= 1'b0;
            ALUOp_ID_EX    <= 2'b00;
            Valid_ID_EX    <= 1'b0;
        end else begin
            RegWrite_ID_EX <= RegWrite_ID & ~bubble;
            MemtoReg_ID_EX <= MemtoReg_ID & ~bubble;
            MemRead_ID_EX  <= MemRead_ID & ~bubble;
            MemWrite_ID_EX <= MemWrite_ID & ~bubble;
            ALUSrc_ID_EX   <= ALUSrc_ID & ~bubble;
            RegDst_ID_EX   <= RegDst_ID & ~bubble;
            ALUOp_ID_EX    <= bubble ? 2'b00 : ALUOp_ID;
            Valid_ID_EX    <= ~bubble;
        end
    end

    // Operands and specifiers load every edge; under a bubble they are don't-care
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ReadData1_ID_EX <= '0;
            ReadData2_ID_EX <= '0;
            SignExt_ID_EX   <= '0;
            Rs_ID_EX        <= 5'd0;
            Rt_ID_EX        <= 5'd0;
            Rd_ID_EX        <= 5'd0;
        end else begin
            ReadData1_ID_EX <= ReadData1_ID;
            ReadData2_ID_EX <= ReadData2_ID;
            SignExt_ID_EX   <= SignExt_ID;
            Rs_ID_EX        <= Rs_IF_ID;
            Rt_ID_EX        <= Rt_IF_ID;
            Rd_ID_EX        <= Rd_IF_ID;
        end
    end

    // Event counters stick at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Stall_Count <= '0;
            Flush_Count <= '0;
        end else begin
            Stall_Count <= Stall_Count + CNT_W'(stall & ~&Stall_Count);
            Flush_Count <= Flush_Count + CNT_W'(Flush & ~&Flush_Count);
        end
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between the ID and EX stages of the 5-stage MIPS datapath, with integrated load-use hazard detection and branch flush. It latches the decoded control signals, operand values and register specifiers, including Rs_ID_EX and Rt_ID_EX, which the forwarding unit in EX consumes. On a load-use hazard it inserts a bubble and freezes PC and IF/ID. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- DATA_W, 32, datapath width of register and immediate operands
- CNT_W, 16, width of each event counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID, RegDst_ID  in  1 each  decoded control from ID
- ALUOp_ID  in  2  ALU op class from ID
- ReadData1_ID, ReadData2_ID, SignExt_ID  in  DATA_W each  register file outputs and sign-extended immediate
- Rs_IF_ID, Rt_IF_ID, Rd_IF_ID  in  5 each  register specifiers of the instruction in ID
- Flush  in  1  branch taken in EX; squash the instruction in ID
- RegWrite_ID_EX, MemtoReg_ID_EX, MemRead_ID_EX, MemWrite_ID_EX, ALUSrc_ID_EX, RegDst_ID_EX  out  1 each  registered control
- ALUOp_ID_EX  out  2  registered ALU op class
- ReadData1_ID_EX, ReadData2_ID_EX, SignExt_ID_EX  out  DATA_W each  registered operands
- Rs_ID_EX, Rt_ID_EX, Rd_ID_EX  out  5 each  registered specifiers (to forwarding unit and destination mux)
- Valid_ID_EX  out  1  EX holds a real instruction (0 = bubble)
- PC_Write  out  1  PC may advance
- IF_ID_Write  out  1  IF/ID register may load
- Stall_Count, Flush_Count  out  CNT_W each  saturating event counters

## Operation
- Hazard detect (combinational): Hazard = MemRead_ID_EX & Valid_ID_EX & (Rt_ID_EX != 0) & ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID)).
- Stall = Hazard & ~Flush. Flush always takes priority over Stall.
- PC_Write = IF_ID_Write = ~Stall.
- Each rising clk edge selects exactly one of three update modes:
  - Flush or Stall (bubble): all seven control outputs load 0, Valid_ID_EX loads 0. Data and specifier fields load the ID inputs, but are don't-care because the controls are zero.
  - Otherwise (normal): every _ID_EX output loads its corresponding _ID/_IF_ID input, and Valid_ID_EX loads 1.
- The register has no hold mode. A stall holds upstream state only; ID/EX always takes a bubble.
- Stall_Count increments by 1 on each edge where Stall=1. Flush_Count increments by 1 on each edge where Flush=1. Both saturate at 2^CNT_W−1 and never wrap.
- Bubble control values guarantee no register or memory write, so the forwarding unit never matches a bubble.

## Timing
- Reset (async assert, immediate): all _ID_EX outputs 0, Valid_ID_EX 0, both counters 0. PC_Write and IF_ID_Write therefore read 1 while in reset.
- Reset asserted mid-stall drops the stall immediately. The held load is discarded and no counter increment occurs.
- Latency: one cycle, ID inputs to _ID_EX outputs.
- Hazard outputs are combinational from current ID/EX state and the IF/ID specifiers, valid in the same cycle.
- A load-use stall lasts exactly one cycle. After the bubble, MemRead_ID_EX=0, so Hazard deasserts and the dependent instruction advances. Forwarding then supplies the load data from MEM/WB.
- Back-to-back loads with chained dependencies each stall one cycle independently.
- Simultaneous Flush and Hazard: bubble inserted, PC_Write=1, Flush_Count+1, Stall_Count unchanged.

## Test plan
- Reset: assert rst mid-cycle with nonzero inputs -> all outputs 0 at once, PC_Write=1, counters 0; deassert, then one clock with RegWrite_ID=1, Rd_IF_ID=5 -> RegWrite_ID_EX=1, Rd_ID_EX=5, Valid_ID_EX=1.
- Pass-through: ReadData1_ID=0xDEADBEEF, Rs_IF_ID=3, ALUOp_ID=2'b10 -> after one edge ReadData1_ID_EX=0xDEADBEEF, Rs_ID_EX=3, ALUOp_ID_EX=2'b10.
- Load-use: lw $t1 (Rt=9, MemRead=1) in ID/EX, ID instruction Rs_IF_ID=9 -> PC_Write=0, IF_ID_Write=0; next edge: all controls 0, Valid 0, Stall_Count=1; following cycle PC_Write=1.
- $0 and no-dependency: lw with Rt_ID_EX=0 and Rs_IF_ID=0 -> no stall; lw Rt=9 with Rs=4, Rt=5 in ID -> no stall.
- Flush priority: load hazard present and Flush=1 together -> PC_Write=1; next edge: bubble, Flush_Count=1, Stall_Count=0.
- Saturation: with CNT_W=4, force 20 consecutive stall cycles -> Stall_Count holds at 15.
